// File: rtl/pipe_decoder_if.sv
// Handshake bundle between the CPU pipeline control and the pipelined decoder.
// PIPE_DECODER_HIST_EN adds the strobe-history signals.
interface pipe_decoder_if #(
   parameter int IN_W = 2
);
   localparam int OUT_W = 1 << IN_W;

   logic             in_valid;
   logic             en;
   logic [IN_W-1:0]  in;
   logic             stall;
   logic             flush;
   logic [OUT_W-1:0] out;
   logic             out_valid;
   logic             busy;
`ifdef PIPE_DECODER_HIST_EN
   logic             clr_hist;
   logic [OUT_W-1:0] hist;
   logic [7:0]       hist_cnt;
`endif

`ifdef PIPE_DECODER_HIST_EN
   modport master (
      output in_valid, en, in, stall, flush, clr_hist,
      input  out, out_valid, busy, hist, hist_cnt
   );
   modport slave (
      input  in_valid, en, in, stall, flush, clr_hist,
      output out, out_valid, busy, hist, hist_cnt
   );
`else
   modport master (
      output in_valid, en, in, stall, flush,
      input  out, out_valid, busy
   );
   modport slave (
      input  in_valid, en, in, stall, flush,
      output out, out_valid, busy
   );
`endif
endinterface

// File: rtl/pipe_decoder.sv
// Pipelined N-to-2^N one-hot decoder with stall/flush, producing register-file write strobes.
// Optional feature macro: PIPE_DECODER_HIST_EN (sticky strobe history and hit counter).
module pipe_decoder #(
   parameter int IN_W   = 2,
   parameter int STAGES = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   pipe_decoder_if.slave bus
);
   localparam int OUT_W = 1 << IN_W;

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [OUT_W-1:0]  data_q [STAGES];
   logic [OUT_W-1:0]  data_d [STAGES];
   logic [OUT_W-1:0]  dec;

   // A valid slot with en=0 still travels, carrying an all-zero strobe.
   always_comb begin
      dec = '0;
      if (bus.in_valid && bus.en) begin
         dec[bus.in] = 1'b1;
      end
   end

   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < STAGES; i++) begin
         data_d[i] = data_q[i];
      end
      if (bus.flush) begin
         valid_d = '0;
         for (int i = 0; i < STAGES; i++) begin
            data_d[i] = '0;
         end
      end else if (!bus.stall) begin
         valid_d[0] = bus.in_valid;
         data_d[0]  = dec;
         for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign bus.out       = data_q[STAGES-1];
   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.busy      = |valid_q;

`ifdef PIPE_DECODER_HIST_EN
   logic [OUT_W-1:0] hist_q;
   logic [OUT_W-1:0] hist_d;
   logic [7:0]       hist_cnt_q;
   logic [7:0]       hist_cnt_d;
   logic             accept;
   logic             hit;

   // A slot is consumed downstream only when it is live and the pipe advances.
   assign accept = bus.out_valid && !bus.stall;
   assign hit    = accept && (bus.out != '0);

   always_comb begin
      hist_d     = hist_q;
      hist_cnt_d = hist_cnt_q;
      if (bus.clr_hist) begin
         hist_d     = accept ? bus.out : '0;
         hist_cnt_d = hit ? 8'd1 : 8'd0;
      end else begin
         if (accept) begin
            hist_d = hist_q | bus.out;
         end
         if (hit && hist_cnt_q != 8'hFF) begin
            hist_cnt_d = hist_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q     <= '0;
         hist_cnt_q <= '0;
      end else begin
         hist_q     <= hist_d;
         hist_cnt_q <= hist_cnt_d;
      end
   end

   assign bus.hist     = hist_q;
   assign bus.hist_cnt = hist_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_decoder.sv
// Self-checking bench for pipe_decoder: directed vector table, scoreboarded random stream,
// asynchronous reset, a wide/deep instance and (with PIPE_DECODER_HIST_EN) the history block.
module tb_pipe_decoder;
   localparam int IN_W   = 2;
   localparam int STAGES = 2;
   localparam int OUT_W  = 1 << IN_W;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pipe_decoder_if #(.IN_W(IN_W)) bus ();
   pipe_decoder #(.IN_W(IN_W), .STAGES(STAGES)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   pipe_decoder_if #(.IN_W(4)) bus4 ();
   pipe_decoder #(.IN_W(4), .STAGES(4)) dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus4.slave)
   );

   typedef struct packed {
      logic             v;
      logic [OUT_W-1:0] d;
   } slot_t;

   typedef struct packed {
      logic             iv;
      logic             en;
      logic [IN_W-1:0]  sel;
      logic             st;
      logic             fl;
      logic [OUT_W-1:0] exp_out;
      logic             exp_v;
      logic             exp_busy;
   } vec_t;

   localparam int NVEC = 19;
   vec_t  vecs [NVEC];
   slot_t sb_q [$];
   slot_t sb_final;
   int    tests = 0;
   int    fails = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Queue holds slots in the stages before the output; the front pops into sb_final.
   task automatic sbReset();
      sb_q.delete();
      for (int i = 0; i < STAGES - 1; i++) begin
         sb_q.push_back('0);
      end
      sb_final = '0;
   endtask

   task automatic sbUpdate(input logic iv, input logic e, input logic [IN_W-1:0] sel,
                           input logic st, input logic fl);
      slot_t s;
      if (fl) begin
         sbReset();
      end else if (!st) begin
         s.v = iv;
         s.d = (iv && e) ? (OUT_W'(1) << sel) : '0;
         sb_q.push_back(s);
         sb_final = sb_q.pop_front();
      end
   endtask

   task automatic checkScoreboard(input string tag);
      logic exp_busy;
      exp_busy = sb_final.v;
      foreach (sb_q[i]) exp_busy = exp_busy | sb_q[i].v;
      checkOutput({tag, " sb out"}, 32'(bus.out), 32'(sb_final.d));
      checkOutput({tag, " sb out_valid"}, 32'(bus.out_valid), 32'(sb_final.v));
      checkOutput({tag, " sb busy"}, 32'(bus.busy), 32'(exp_busy));
      checkOutput({tag, " onehot"}, 32'($countones(bus.out) > 1), 32'd0);
   endtask

   task automatic applyStimulus(input logic iv, input logic e, input logic [IN_W-1:0] sel,
                                input logic st, input logic fl, input string tag);
      bus.in_valid = iv;
      bus.en       = e;
      bus.in       = sel;
      bus.stall    = st;
      bus.flush    = fl;
      @(posedge clk);
      sbUpdate(iv, e, sel, st, fl);
      #1;
      checkScoreboard(tag);
   endtask

   initial begin
      // Directed rows: inputs before an edge, expected outputs just after it.
      vecs[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b1};
      vecs[15] = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
      vecs[18] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.en        = 1'b0;
      bus.in        = '0;
      bus.stall     = 1'b0;
      bus.flush     = 1'b0;
      bus4.in_valid = 1'b0;
      bus4.en       = 1'b0;
      bus4.in       = '0;
      bus4.stall    = 1'b0;
      bus4.flush    = 1'b0;
`ifdef PIPE_DECODER_HIST_EN
      bus.clr_hist  = 1'b0;
      bus4.clr_hist = 1'b0;
`endif
      sbReset();

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset out", 32'(bus.out), 32'd0);
      checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].iv, vecs[i].en, vecs[i].sel, vecs[i].st, vecs[i].fl,
                       $sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d out", i), 32'(bus.out), 32'(vecs[i].exp_out));
         checkOutput($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_v));
         checkOutput($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
      end

      // Reset asserted between edges with two slots in flight must clear at once.
      applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "pre-reset a");
      applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, "pre-reset b");
      checkOutput("pre-reset out", 32'(bus.out), 32'h8);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset out", 32'(bus.out), 32'd0);
      checkOutput("async reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("async reset busy", 32'(bus.busy), 32'd0);
      sbReset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "post-reset a");
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "post-reset b");
      checkOutput("post-reset first slot", 32'(bus.out), 32'h2);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                       IN_W'($urandom_range(0, OUT_W - 1)), 1'($urandom_range(0, 4) == 0),
                       1'($urandom_range(0, 19) == 0), $sformatf("rnd%0d", i));
      end

      // Default pipe is stalled so the scoreboard stays valid while the wide instance runs.
      bus.stall     = 1'b1;
      bus4.in_valid = 1'b1;
      bus4.en       = 1'b1;
      bus4.in       = 4'hA;
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      bus4.in       = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("w4 edge3 out_valid", 32'(bus4.out_valid), 32'd0);
      checkOutput("w4 edge3 busy", 32'(bus4.busy), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("w4 edge4 out", 32'(bus4.out), 32'h0400);
      checkOutput("w4 edge4 out_valid", 32'(bus4.out_valid), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("w4 drained busy", 32'(bus4.busy), 32'd0);
`ifdef PIPE_DECODER_HIST_EN
      checkOutput("w4 hist", 32'(bus4.hist), 32'h0400);
      checkOutput("w4 hist_cnt", 32'(bus4.hist_cnt), 32'd1);
`endif
      checkScoreboard("stalled during w4");

`ifdef PIPE_DECODER_HIST_EN
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "hist drain a");
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "hist drain b");
      bus.clr_hist = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "hist clear");
      bus.clr_hist = 1'b0;
      checkOutput("hist cleared", 32'(bus.hist), 32'd0);
      checkOutput("hist_cnt cleared", 32'(bus.hist_cnt), 32'd0);
      applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "hist s1");
      applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "hist s3");
      applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, "hist s1b");
      repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "hist tail");
      checkOutput("hist 1,3,1", 32'(bus.hist), 32'hA);
      checkOutput("hist_cnt 1,3,1", 32'(bus.hist_cnt), 32'd3);
      applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, "hist s2");
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "hist s2 out");
      bus.clr_hist = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "hist clr+accept");
      bus.clr_hist = 1'b0;
      checkOutput("hist clr+accept", 32'(bus.hist), 32'h4);
      checkOutput("hist_cnt clr+accept", 32'(bus.hist_cnt), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipe_decoder.md
Name: pipe_decoder

Overview:
- Parametrised, pipelined N-to-2^N one-hot decoder with enable. It is the registered successor of the combinational 2-to-4 decoder.
- Used in the pipelined CPU to generate register-file write-enable strobes aligned to a pipeline stage boundary.
- Supports configurable latency, stall (hold), and flush (squash) so the strobes track the CPU pipeline's valid/bubble flow.

Parameters:
- IN_W, 2, width of the encoded select input; output width is 2**IN_W (legal 1..6).
- STAGES, 2, pipeline register depth = latency in cycles (legal 1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a pipeline slot is entering this cycle.
- en  input  1  decode enable for the entering slot; 0 gives an all-zero decode.
- in  input  IN_W  encoded select.
- stall  input  1  hold all stages; no advance.
- flush  input  1  squash every in-flight slot.
- out  output  2**IN_W  one-hot (or zero) decoded strobe from the final stage.
- out_valid  output  1  the final stage holds a live slot.
- busy  output  1  OR of the valid bits of all stages.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- While reset_n=0: every stage valid=0 and data=0, so out=0, out_valid=0, busy=0. This applies immediately, without waiting for a clock edge.
- Decode of the entering slot: d[k] = in_valid & en & (in==k) for k in 0..2**IN_W-1. At most one bit is set.
- Stage 0 captures {in_valid, d}. Stage i captures stage i-1. out and out_valid come from stage STAGES-1.
- Latency: a slot applied at edge t appears on out at edge t+STAGES-1 (registered output, STAGES clock edges after input sampled counting from the capture edge). With STAGES=2, input sampled at edge 0 is visible after edge 1.
- in_valid=1, en=0: the slot travels with valid=1 and data=0, so out_valid=1 and out=0. This keeps the slot count exact.
- in_valid=0: a bubble with valid=0 and data=0.
- Stall: all stage registers hold and the input is ignored (not captured). The upstream side must re-present the input.
- Flush: on the next edge all stage valid and data bits go to 0. The input presented that cycle is also discarded.
- Flush has priority over stall.
- flush and stall together: all stages are cleared.
- Reset asserted mid-operation clears everything asynchronously. Deassertion is synchronised by the system. After deassertion, the first slot enters on the next edge.
- Invariant: out has at most one bit set. out != 0 implies out_valid=1.
- busy=1 whenever any stage valid=1. busy is combinational from the registers.
- STAGES=1 degenerates to a single registered decoder stage.

Optional Feature:
- Macro PIPE_DECODER_HIST_EN.
- When defined, adds inputs clr_hist (1 bit) and outputs hist (2**IN_W bits) and hist_cnt (8 bits).
- hist is a sticky OR of every out accepted while out_valid=1 and stall=0.
- hist_cnt counts those accepted slots with out!=0 and saturates at 255.
- clr_hist=1 zeroes both. If clr_hist and an accept occur in the same cycle, hist<=out and hist_cnt<=1 (or 0 if out=0).
- Reset zeroes hist and hist_cnt.
- When the macro is undefined, these ports and registers do not exist and the core behaviour is identical.

Test Plan:
- Reset: reset_n=0 asserted mid-stream with slots in flight -> out=0, out_valid=0, busy=0 immediately, before the next edge.
- Sweep with defaults: in_valid=1, en=1, in=0,1,2,3 on consecutive cycles -> out=0001,0010,0100,1000 with out_valid=1, each one cycle after its input edge.
- Enable low: en=0, in=2'b10, in_valid=1 -> out=0000, out_valid=1. Then in_valid=0 -> out_valid=0, busy drops once the pipe drains.
- Stall: stall=1 for 3 cycles while 0010 sits in the final stage and in changes -> out holds 0010. The changing input is never captured. After release, the next slot follows.
- Flush with stall: pipe holding in=3 and in=1, flush=1 and stall=1 in the same cycle -> next edge out=0, out_valid=0, busy=0.
- Parametric check with IN_W=4, STAGES=4: in=4'hA -> out=16'h0400 after 4 edges. With PIPE_DECODER_HIST_EN, after in=1,3,1 -> hist=4'b1010, hist_cnt=3.
